reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised power-on/soft reset sequencer for the chip top level. Holds NUM_STAGES reset
//  domains (e.g. loader+UART+inst mem, then core+main mem, ...) in reset and releases them
//  strictly in order. Each later stage waits for the previous stage's done handshake, or a timeout.
//  Adds a runtime soft-reset request, per-stage done gating, timeout detection and status outputs.
// PARAMETERS
//  NUM_STAGES    4     number of reset domains, >=1; stage 0 released first
//  COUNT_WIDTH   16    width of the internal down-counter
//  INIT_HOLD     15    cycles all stages stay in reset after reset/soft reset ends
//  STAGE_GAP     4     cycles between done[k] accepted and stage_reset[k+1] deasserting
//  DONE_TIMEOUT  1024  max cycles waiting on stage_done[k]; 0 = no wait, done ignored
// PORTS
//  clk             in   1              clock
//  reset           in   1              synchronous, active-high; restarts sequence, clears errors
//  soft_reset_req  in   1              1-cycle pulse; restarts sequence, keeps timeout_error
//  stage_done      in   NUM_STAGES     level, stage k finished init (e.g. loader completed)
//  stage_reset     out  NUM_STAGES     active-high reset per domain, registered
//  all_released    out  1              all stages released and last done seen, registered
//  current_stage   out  $clog2(NUM_STAGES+1)  index of stage being waited on; NUM_STAGES=running
//  timeout_error   out  1              sticky: some stage timed out waiting for done
// BEHAVIOUR
//  Reset values: stage_reset='1, all_released=0, current_stage=0, timeout_error=0, state=HOLD,
//   counter=INIT_HOLD. reset has priority over soft_reset_req and stage_done.
//  States: HOLD -> WAIT_DONE -> (GAP -> WAIT_DONE)* -> RUNNING.
//  HOLD: counter decrements each cycle; when counter==0, stage_reset[0]<=0 and go to WAIT_DONE.
//   After reset is sampled at edge E, stage_reset[0] falls at edge E+INIT_HOLD+1
//   (INIT_HOLD=0 -> at E+1).
//  WAIT_DONE(k): counter loaded with DONE_TIMEOUT on entry. Minimum one cycle in state.
//   stage_done[k] sampled each cycle; stage_done[j], j!=k, ignored.
//   stage_done[k]=1 -> k==last: RUNNING, all_released<=1, current_stage<=NUM_STAGES;
//   else GAP with counter=STAGE_GAP.
//   counter==0 with done still low -> timeout_error<=1, proceed as if done.
//   DONE_TIMEOUT=0 -> leave after exactly one cycle, no error.
//  GAP: decrement; counter==0 -> stage_reset[k+1]<=0, current_stage<=k+1, WAIT_DONE(k+1).
//   STAGE_GAP=0 -> release on the cycle after done is accepted.
//  RUNNING: outputs static until reset/soft reset; stage_done changes ignored.
//  A released stage never re-enters reset except via reset or soft_reset_req.
//  soft_reset_req in any state: next edge stage_reset<='1, all_released<=0, current_stage<=0,
//   state=HOLD, counter=INIT_HOLD; timeout_error unchanged. Request during HOLD restarts the count.
//  Simultaneous soft_reset_req and stage_done[k]: soft reset wins, done discarded.
//  Counter arithmetic unsigned COUNT_WIDTH, never wraps (stops at 0).
//   INIT_HOLD, STAGE_GAP and DONE_TIMEOUT must fit COUNT_WIDTH (elaboration assertion).
//  stage_reset bits change only on the documented edges, glitch-free (flop outputs).
// STRUCTURE
//  Package reset_seq_pkg: typedef enum logic[1:0] {HOLD, WAIT_DONE, GAP, RUNNING} rseq_state_t;
//   default constants RSEQ_INIT_HOLD=15, RSEQ_STAGE_GAP=4, RSEQ_DONE_TIMEOUT=1024.
//  One sub-module: reset_countdown (load value, load strobe, dec enable, zero flag),
//   COUNT_WIDTH-parametrised, reused for hold/gap/timeout.
//  Chip top: stage0=loader/UART/inst mem, stage1=core/main mem with done=loader completed.
// TESTING
//  NUM_STAGES=2, INIT_HOLD=15, reset 1 cycle -> stage_reset[0] falls 16 edges later,
//   stage_reset[1] still 1.
//  done[0] asserted 40 cycles after release, STAGE_GAP=4 -> stage_reset[1] falls 5 edges after
//   done sampled; done[1]=1 -> all_released=1, current_stage=2, timeout_error=0.
//  DONE_TIMEOUT=8, done[0] never -> timeout_error=1 after 8 cycles in WAIT_DONE;
//   stage 1 released after GAP; error stays 1 through soft reset, clears on reset.
//  soft_reset_req in RUNNING -> next edge stage_reset=2'b11, all_released=0;
//   sequence repeats with identical timing.
//  soft_reset_req same cycle as done[0] -> done ignored, HOLD restarts;
//   done[1] high early while in stage 0 -> no effect.
//  INIT_HOLD=0, STAGE_GAP=0, DONE_TIMEOUT=0, NUM_STAGES=4 -> stages release on consecutive
//   2-cycle steps, all_released within 9 cycles of reset.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    WAIT_DONE,
    GAP,
    RUNNING
  } rseq_state_t;

  localparam int RSEQ_INIT_HOLD    = 15;
  localparam int RSEQ_STAGE_GAP    = 4;
  localparam int RSEQ_DONE_TIMEOUT = 1024;

endpackage

// File: rtl/reset_countdown.sv
// Saturating down-counter shared by the hold, gap and timeout phases.
// A load takes priority over a decrement; the count stops at zero.
module reset_countdown #(
  parameter int COUNT_WIDTH = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   dec_en,
  output logic                   zero
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  // next count: load wins, otherwise decrement without wrapping below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  // count register, restarts at the hold length
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= COUNT_WIDTH'(RESET_VALUE);
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_STAGES reset domains. Stage 0 leaves reset after
// an initial hold; each later stage waits for the previous stage's done
// (or a timeout) plus a fixed gap. A soft reset restarts the sequence but
// keeps the sticky timeout flag.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int  NUM_STAGES   = 4,
  parameter int  COUNT_WIDTH  = 16,
  parameter int  INIT_HOLD    = RSEQ_INIT_HOLD,
  parameter int  STAGE_GAP    = RSEQ_STAGE_GAP,
  parameter int  DONE_TIMEOUT = RSEQ_DONE_TIMEOUT,
  localparam int CS_W         = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_released,
  output logic [CS_W-1:0]       current_stage,
  output logic                  timeout_error
);

  localparam logic [COUNT_WIDTH-1:0] HOLD_LOAD    = COUNT_WIDTH'(INIT_HOLD);
  localparam logic [COUNT_WIDTH-1:0] GAP_LOAD     = COUNT_WIDTH'(STAGE_GAP);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LOAD = COUNT_WIDTH'(DONE_TIMEOUT);
  localparam logic [CS_W-1:0]        LAST_STAGE   = CS_W'(NUM_STAGES - 1);
  localparam logic [CS_W-1:0]        RUN_INDEX    = CS_W'(NUM_STAGES);

  // reject parameter sets the counter cannot represent
  if (NUM_STAGES < 1) begin : g_bad_num_stages
    $error("reset_sequencer: NUM_STAGES must be >= 1");
  end
  if (INIT_HOLD < 0 || (longint'(INIT_HOLD) >> COUNT_WIDTH) != 0) begin : g_bad_init_hold
    $error("reset_sequencer: INIT_HOLD does not fit COUNT_WIDTH");
  end
  if (STAGE_GAP < 0 || (longint'(STAGE_GAP) >> COUNT_WIDTH) != 0) begin : g_bad_stage_gap
    $error("reset_sequencer: STAGE_GAP does not fit COUNT_WIDTH");
  end
  if (DONE_TIMEOUT < 0 || (longint'(DONE_TIMEOUT) >> COUNT_WIDTH) != 0) begin : g_bad_timeout
    $error("reset_sequencer: DONE_TIMEOUT does not fit COUNT_WIDTH");
  end

  rseq_state_t            state_q, state_d;
  logic [NUM_STAGES-1:0]  stage_reset_q, stage_reset_d;
  logic                   all_released_q, all_released_d;
  logic [CS_W-1:0]        current_stage_q, current_stage_d;
  logic                   timeout_error_q, timeout_error_d;

  logic                   cnt_load;
  logic [COUNT_WIDTH-1:0] cnt_load_value;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic                   done_sel;

  reset_countdown #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .RESET_VALUE (INIT_HOLD)
  ) u_countdown (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec_en     (cnt_dec),
    .zero       (cnt_zero)
  );

  // only the done of the stage currently being waited on matters
  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (current_stage_q == CS_W'(i)) begin
        done_sel = stage_done[i];
      end
    end
  end

  // next state, counter control and output updates
  always_comb begin
    state_d         = state_q;
    stage_reset_d   = stage_reset_q;
    all_released_d  = all_released_q;
    current_stage_d = current_stage_q;
    timeout_error_d = timeout_error_q;
    cnt_load        = 1'b0;
    cnt_load_value  = '0;
    cnt_dec         = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (cnt_zero) begin
          stage_reset_d[0] = 1'b0;
          state_d          = WAIT_DONE;
          cnt_load         = 1'b1;
          cnt_load_value   = TIMEOUT_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WAIT_DONE: begin
        // a zero timeout leaves the counter at zero, so the stage exits after one cycle
        if (done_sel || cnt_zero) begin
          if (!done_sel && (DONE_TIMEOUT != 0)) begin
            timeout_error_d = 1'b1;
          end
          if (current_stage_q == LAST_STAGE) begin
            state_d         = RUNNING;
            all_released_d  = 1'b1;
            current_stage_d = RUN_INDEX;
          end else begin
            state_d        = GAP;
            cnt_load       = 1'b1;
            cnt_load_value = GAP_LOAD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          for (int i = 1; i < NUM_STAGES; i++) begin
            if (current_stage_q == CS_W'(i - 1)) begin
              stage_reset_d[i] = 1'b0;
            end
          end
          current_stage_d = current_stage_q + CS_W'(1);
          state_d         = WAIT_DONE;
          cnt_load        = 1'b1;
          cnt_load_value  = TIMEOUT_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RUNNING: begin
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    // soft reset overrides everything above, including a done seen this cycle
    if (soft_reset_req) begin
      state_d         = HOLD;
      stage_reset_d   = '1;
      all_released_d  = 1'b0;
      current_stage_d = '0;
      timeout_error_d = timeout_error_q;
      cnt_load        = 1'b1;
      cnt_load_value  = HOLD_LOAD;
      cnt_dec         = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= HOLD;
      stage_reset_q   <= '1;
      all_released_q  <= 1'b0;
      current_stage_q <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stage_reset_q   <= stage_reset_d;
      all_released_q  <= all_released_d;
      current_stage_q <= current_stage_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  assign stage_reset   = stage_reset_q;
  assign all_released  = all_released_q;
  assign current_stage = current_stage_q;
  assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three instances (nominal, short timeout, all-zero
// timing) checked every cycle against a deadline-based model, plus literal
// edge-distance checks.
module tb_reset_sequencer;

  localparam int NS_A = 2, IH_A = 15, SG_A = 4, TO_A = 1024;
  localparam int NS_B = 2, IH_B = 15, SG_B = 4, TO_B = 8;
  localparam int NS_C = 4, IH_C = 0,  SG_C = 0, TO_C = 0;

  int NS [3] = '{NS_A, NS_B, NS_C};
  int IH [3] = '{IH_A, IH_B, IH_C};
  int SG [3] = '{SG_A, SG_B, SG_C};
  int TO [3] = '{TO_A, TO_B, TO_C};

  logic clk;
  logic rst_a, rst_b, rst_c, soft_a, soft_b, soft_c;
  logic [1:0] done_a, done_b;
  logic [3:0] done_c;
  logic [1:0] a_sr, b_sr, a_cs, b_cs;
  logic [3:0] c_sr;
  logic [2:0] c_cs;
  logic a_all, b_all, c_all, a_err, b_err, c_err;

  logic       rst_n  [3];
  logic       soft_n [3];
  logic [3:0] done_n [3];
  logic [3:0] o_sr   [3];
  logic       o_all  [3];
  logic [2:0] o_cs   [3];
  logic       o_err  [3];

  assign rst_n[0] = rst_a;  assign rst_n[1] = rst_b;  assign rst_n[2] = rst_c;
  assign soft_n[0] = soft_a; assign soft_n[1] = soft_b; assign soft_n[2] = soft_c;
  assign done_n[0] = {2'b00, done_a}; assign done_n[1] = {2'b00, done_b}; assign done_n[2] = done_c;
  assign o_sr[0] = {2'b00, a_sr}; assign o_sr[1] = {2'b00, b_sr}; assign o_sr[2] = c_sr;
  assign o_cs[0] = {1'b0, a_cs};  assign o_cs[1] = {1'b0, b_cs};  assign o_cs[2] = c_cs;
  assign o_all[0] = a_all; assign o_all[1] = b_all; assign o_all[2] = c_all;
  assign o_err[0] = a_err; assign o_err[1] = b_err; assign o_err[2] = c_err;

  reset_sequencer #(.NUM_STAGES(NS_A), .COUNT_WIDTH(16), .INIT_HOLD(IH_A),
                    .STAGE_GAP(SG_A), .DONE_TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(rst_a), .soft_reset_req(soft_a), .stage_done(done_a),
    .stage_reset(a_sr), .all_released(a_all), .current_stage(a_cs), .timeout_error(a_err));

  reset_sequencer #(.NUM_STAGES(NS_B), .COUNT_WIDTH(16), .INIT_HOLD(IH_B),
                    .STAGE_GAP(SG_B), .DONE_TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(rst_b), .soft_reset_req(soft_b), .stage_done(done_b),
    .stage_reset(b_sr), .all_released(b_all), .current_stage(b_cs), .timeout_error(b_err));

  reset_sequencer #(.NUM_STAGES(NS_C), .COUNT_WIDTH(16), .INIT_HOLD(IH_C),
                    .STAGE_GAP(SG_C), .DONE_TIMEOUT(TO_C)) dut_c (
    .clk(clk), .reset(rst_c), .soft_reset_req(soft_c), .stage_done(done_c),
    .stage_reset(c_sr), .all_released(c_all), .current_stage(c_cs), .timeout_error(c_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit fin [3]  = '{0, 0, 0};

  // model: deadlines in absolute edge numbers
  // mode 0 = holding for stage 0, 1 = waiting for done of m_cs, 2 = gap, 3 = running
  bit         m_valid [3] = '{0, 0, 0};
  logic [3:0] m_sr    [3];
  logic       m_all   [3];
  int         m_cs    [3];
  logic       m_err   [3];
  int         m_mode  [3];
  int         m_evt   [3];
  int         rst_edge  [3];
  int         soft_edge [3];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i] || soft_n[i]) begin
        if (rst_n[i]) begin
          m_err[i] = 1'b0; m_valid[i] = 1'b1; rst_edge[i] = cyc;
        end else begin
          soft_edge[i] = cyc;
        end
        m_sr[i]   = 4'((1 << NS[i]) - 1);
        m_all[i]  = 1'b0;
        m_cs[i]   = 0;
        m_mode[i] = 0;
        m_evt[i]  = cyc + IH[i] + 1;
      end else if (m_valid[i]) begin
        case (m_mode[i])
          0: if (cyc == m_evt[i]) begin
            m_sr[i][0] = 1'b0; m_mode[i] = 1; m_evt[i] = cyc + TO[i] + 1;
          end
          1: begin
            bit got;
            got = done_n[i][m_cs[i]];
            if (TO[i] == 0 || got || cyc == m_evt[i]) begin
              if (TO[i] != 0 && !got) m_err[i] = 1'b1;
              if (m_cs[i] == NS[i] - 1) begin
                m_all[i] = 1'b1; m_cs[i] = NS[i]; m_mode[i] = 3;
              end else begin
                m_mode[i] = 2; m_evt[i] = cyc + SG[i] + 1;
              end
            end
          end
          2: if (cyc == m_evt[i]) begin
            m_cs[i] = m_cs[i] + 1; m_sr[i][m_cs[i]] = 1'b0;
            m_mode[i] = 1; m_evt[i] = cyc + TO[i] + 1;
          end
          default: ;
        endcase
      end
    end
  end

  // edge monitor and per-cycle comparison against the model
  int   fall_edge [3][4];
  int   all_edge  [3];
  int   err_edge  [3];
  logic [3:0] prev_sr [3];
  logic prev_all [3];
  logic prev_err [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (prev_sr[i][b] === 1'b1 && o_sr[i][b] === 1'b0) fall_edge[i][b] = cyc;
        end
        if (prev_all[i] !== 1'b1 && o_all[i] === 1'b1) all_edge[i] = cyc;
        if (prev_err[i] !== 1'b1 && o_err[i] === 1'b1) err_edge[i] = cyc;
        prev_sr[i] = o_sr[i]; prev_all[i] = o_all[i]; prev_err[i] = o_err[i];
        n_checks++;
        if (o_sr[i] !== m_sr[i] || o_all[i] !== m_all[i] ||
            o_cs[i] !== 3'(m_cs[i]) || o_err[i] !== m_err[i]) begin
          n_fail++;
          $display("FAIL model_cmp dut%0d edge %0d: sr=%b want %b all=%b want %b cs=%0d want %0d err=%b want %b",
                   i, cyc, o_sr[i], m_sr[i], o_all[i], m_all[i], o_cs[i], m_cs[i], o_err[i], m_err[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // kind 0..3: stage_reset[kind] low, 4: all_released high, 5: timeout_error high
  task automatic wait_ev(input int i, input int kind, input int limit, input string nm);
    int t;
    bit hit;
    t = 0; hit = 1'b0;
    while (!hit && t < limit) begin
      @(negedge clk);
      t++;
      if (kind < 4)       hit = (o_sr[i][kind] === 1'b0);
      else if (kind == 4) hit = (o_all[i] === 1'b1);
      else                hit = (o_err[i] === 1'b1);
    end
    #1;
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: event not seen within %0d cycles, got none, required one", nm, limit);
    end
  endtask

  // instance A: nominal handshake timing, soft reset, done/soft collision
  initial begin : thr_a
    int dset;
    rst_a = 1'b0; soft_a = 1'b0; done_a = 2'b00;
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    chk("a_reset_sr", int'(a_sr), 3);
    chk("a_reset_all", int'(a_all), 0);
    wait_ev(0, 0, 40, "a_wait_rel0");
    chk("a_rel0_delay", fall_edge[0][0] - rst_edge[0], 16);
    chk("a_sr1_held", int'(a_sr[1]), 1);
    repeat (40) @(negedge clk);
    done_a = 2'b01; dset = cyc + 1;
    wait_ev(0, 1, 20, "a_wait_rel1");
    chk("a_gap", fall_edge[0][1] - dset, 5);
    done_a = 2'b11;
    repeat (2) @(negedge clk);
    chk("a_all_released", int'(a_all), 1);
    chk("a_cs_running", int'(a_cs), 2);
    chk("a_no_error", int'(a_err), 0);
    // soft reset from RUNNING, then identical timing
    done_a = 2'b00;
    @(negedge clk); soft_a = 1'b1;
    @(negedge clk); soft_a = 1'b0;
    chk("a_soft_sr", int'(a_sr), 3);
    chk("a_soft_all", int'(a_all), 0);
    chk("a_soft_cs", int'(a_cs), 0);
    wait_ev(0, 0, 40, "a_wait_rel0_soft");
    chk("a_rel0_soft_delay", fall_edge[0][0] - soft_edge[0], 16);
    repeat (40) @(negedge clk);
    done_a = 2'b01; dset = cyc + 1;
    wait_ev(0, 1, 20, "a_wait_rel1_soft");
    chk("a_gap_soft", fall_edge[0][1] - dset, 5);
    done_a = 2'b11;
    wait_ev(0, 4, 10, "a_wait_all_soft");
    // soft reset coincident with done[0]; done[1] early must not matter
    done_a = 2'b00;
    @(negedge clk); soft_a = 1'b1;
    @(negedge clk); soft_a = 1'b0;
    wait_ev(0, 0, 40, "a_wait_rel0_b");
    @(negedge clk); soft_a = 1'b1; done_a = 2'b11;
    @(negedge clk); soft_a = 1'b0; done_a = 2'b10;
    chk("a_collide_sr", int'(a_sr), 3);
    wait_ev(0, 0, 40, "a_wait_rel0_c");
    chk("a_collide_restart", fall_edge[0][0] - soft_edge[0], 16);
    repeat (20) @(negedge clk);
    chk("a_early_done1_sr1", int'(a_sr[1]), 1);
    chk("a_early_done1_cs", int'(a_cs), 0);
    done_a = 2'b11; dset = cyc + 1;
    wait_ev(0, 4, 20, "a_wait_all_c");
    chk("a_all_after_done0", all_edge[0] - dset, 6);
    fin[0] = 1'b1;
  end

  // instance B: timeouts, sticky error through soft reset, cleared by reset
  initial begin : thr_b
    rst_b = 1'b0; soft_b = 1'b0; done_b = 2'b00;
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0;
    wait_ev(1, 0, 40, "b_wait_rel0");
    chk("b_rel0_delay", fall_edge[1][0] - rst_edge[1], 16);
    wait_ev(1, 5, 20, "b_wait_err");
    chk("b_timeout_delay", err_edge[1] - fall_edge[1][0], 9);
    wait_ev(1, 1, 20, "b_wait_rel1");
    chk("b_gap_after_timeout", fall_edge[1][1] - err_edge[1], 5);
    wait_ev(1, 4, 20, "b_wait_all");
    chk("b_last_timeout", all_edge[1] - fall_edge[1][1], 9);
    @(negedge clk); soft_b = 1'b1;
    @(negedge clk); soft_b = 1'b0;
    chk("b_err_kept_soft", int'(b_err), 1);
    chk("b_soft_sr", int'(b_sr), 3);
    repeat (5) @(negedge clk);
    chk("b_err_still", int'(b_err), 1);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0;
    chk("b_err_cleared", int'(b_err), 0);
    done_b = 2'b11;
    wait_ev(1, 4, 40, "b_wait_all_clean");
    chk("b_clean_all_delay", all_edge[1] - rst_edge[1], 23);
    chk("b_clean_no_err", int'(b_err), 0);
    fin[1] = 1'b1;
  end

  // instance C: zero hold, gap and timeout with four stages
  initial begin : thr_c
    rst_c = 1'b0; soft_c = 1'b0; done_c = 4'b0000;
    @(negedge clk); rst_c = 1'b1;
    @(negedge clk); rst_c = 1'b0;
    wait_ev(2, 4, 20, "c_wait_all");
    chk("c_all_delay", all_edge[2] - rst_edge[2], 8);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("c_rel%0d_delay", b), fall_edge[2][b] - rst_edge[2], 1 + 2 * b);
    end
    chk("c_cs_running", int'(c_cs), 4);
    chk("c_no_err", int'(c_err), 0);
    fin[2] = 1'b1;
  end

  initial begin : summary
    wait (fin[0] && fin[1] && fin[2]);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    $fatal(1);
  end

endmodule
